// File: rtl/adder_cla_pipe.sv
// 2-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 registers the operands and per-group G/P; stage 2 resolves the carries and registers the result.
module adder_cla_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             g,
  output logic             p
);

  localparam int NG = WIDTH / GROUP;

  if (GROUP < 1 || GROUP > WIDTH || (WIDTH % GROUP) != 0) begin : g_bad_group
    $error("adder_cla_pipe: WIDTH must be a non-zero multiple of GROUP");
  end

  logic             r_s1_vld;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_y;
  logic             r_cin;
  logic [NG-1:0]    r_grp_g;
  logic [NG-1:0]    r_grp_p;

  logic             r_s2_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_g;
  logic             r_p;

  logic             w_adv1;
  logic             w_adv2;

  assign w_adv2   = ~r_s2_vld | out_ready;
  assign w_adv1   = ~r_s1_vld | w_adv2;
  assign in_ready = w_adv1;

  // Stage 1: operand transform and per-group generate/propagate
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [NG-1:0]    w_grp_g;
  logic [NG-1:0]    w_grp_p;

  assign w_y   = sub ? ~b : b;
  assign w_cin = sub ? ~c_in : c_in;

  // Sum-of-products form: G = OR_j (g_j & AND_{m>j} p_m), scanned from the group MSB down.
  always_comb begin
    logic v_pp;
    w_grp_g = '0;
    w_grp_p = '0;
    for (int k = 0; k < NG; k++) begin
      v_pp = 1'b1;
      for (int j = GROUP - 1; j >= 0; j--) begin
        w_grp_g[k] = w_grp_g[k] | (a[k*GROUP+j] & w_y[k*GROUP+j] & v_pp);
        v_pp       = v_pp & (a[k*GROUP+j] | w_y[k*GROUP+j]);
      end
      w_grp_p[k] = v_pp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_a      <= '0;
      r_y      <= '0;
      r_cin    <= 1'b0;
      r_grp_g  <= '0;
      r_grp_p  <= '0;
    end else if (w_adv1) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_a     <= a;
        r_y     <= w_y;
        r_cin   <= w_cin;
        r_grp_g <= w_grp_g;
        r_grp_p <= w_grp_p;
      end
    end
  end

  // Stage 2: group carries, then bit carries inside each group, both as flat lookahead
  logic [NG:0]      w_gc;
  logic             w_word_g;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_bg;
  logic [WIDTH-1:0] w_bp;
  logic [WIDTH-1:0] w_sum;

  assign w_bg = r_a & r_y;
  assign w_bp = r_a | r_y;

  always_comb begin
    logic v_acc;
    logic v_pp;
    w_gc     = '0;
    w_word_g = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      v_acc = 1'b0;
      v_pp  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        v_acc = v_acc | (r_grp_g[j] & v_pp);
        v_pp  = v_pp & r_grp_p[j];
      end
      w_gc[k] = v_acc | (v_pp & r_cin);
      if (k == NG) w_word_g = v_acc;
    end
  end

  always_comb begin
    logic v_acc;
    logic v_pp;
    w_c = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        v_acc = 1'b0;
        v_pp  = 1'b1;
        for (int m = j - 1; m >= 0; m--) begin
          v_acc = v_acc | (w_bg[k*GROUP+m] & v_pp);
          v_pp  = v_pp & w_bp[k*GROUP+m];
        end
        w_c[k*GROUP+j] = v_acc | (v_pp & w_gc[k]);
      end
    end
    w_c[WIDTH] = w_gc[NG];
  end

  assign w_sum = r_a ^ r_y ^ w_c[WIDTH-1:0];

  // Result registers only load on a real beat so they stay put while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_vld <= 1'b0;
      r_sum    <= '0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_g      <= 1'b0;
      r_p      <= 1'b0;
    end else if (w_adv2) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_sum   <= w_sum;
        r_c_out <= w_c[WIDTH];
        r_ovf   <= w_c[WIDTH-1] ^ w_c[WIDTH];
        r_g     <= w_word_g;
        r_p     <= &r_grp_p;
      end
    end
  end

  assign out_valid = r_s2_vld;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign overflow  = r_ovf;
  assign g         = r_g;
  assign p         = r_p;

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Bench for adder_cla_pipe: three groupings (4, 1, 16) share one stimulus stream.
// Directed table, back-pressure, mid-stall reset and a random streaming run.
module tb_adder_cla_pipe;

  localparam int W = 16;
  localparam int NBEATS = 10000;
  localparam int CYC_LIMIT = 60000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic c_in = 1'b0;
  logic sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic [2:0]        in_ready_w;
  logic [2:0]        out_valid_w;
  logic [2:0]        cout_w;
  logic [2:0]        ovf_w;
  logic [2:0]        g_w;
  logic [2:0]        p_w;
  logic [2:0][W-1:0] sum_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int GP = (gi == 0) ? 4 : ((gi == 1) ? 1 : 16);
    adder_cla_pipe #(.WIDTH(W), .GROUP(GP)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_w[gi]),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .sub      (sub),
      .out_valid(out_valid_w[gi]),
      .out_ready(out_ready),
      .sum      (sum_w[gi]),
      .c_out    (cout_w[gi]),
      .overflow (ovf_w[gi]),
      .g        (g_w[gi]),
      .p        (p_w[gi])
    );
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    logic         g;
    logic         p;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] res(input int d);
    return {sum_w[d], cout_w[d], ovf_w[d], g_w[d], p_w[d]};
  endfunction

  // Reference built from plain wide additions, independent of any lookahead structure.
  function automatic logic [19:0] model(input logic [W-1:0] x, input logic [W-1:0] y0,
                                        input logic ci0, input logic s);
    logic [W-1:0] y;
    logic         ci;
    logic [W:0]   full;
    logic [W:0]   gen;
    logic [W-1:0] low;
    y    = s ? ~y0 : y0;
    ci   = s ? ~ci0 : ci0;
    full = {1'b0, x} + {1'b0, y} + {16'b0, ci};
    gen  = {1'b0, x} + {1'b0, y};
    low  = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + {15'b0, ci};
    return {full[W-1:0], full[W], low[W-1] ^ full[W], gen[W], &(x | y)};
  endfunction

  logic [19:0] q[$];
  logic [19:0] exp_r;
  int idx, got, sent, cyc;
  logic acc;

  initial begin
    tv[0]  = '{16'h1234, 16'h0FF0, 1'b0, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[5]  = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[10] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[11] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid_w), 32'd0);
    for (int d = 0; d < 3; d++) chk($sformatf("rst_res_g%0d", d), 32'(res(d)), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready_w), 32'h7);

    // Directed table, one beat at a time, latency checked
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = tv[i].a; b = tv[i].b; c_in = tv[i].cin; sub = tv[i].sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_early", i), 32'(out_valid_w), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid_w), 32'h7);
      for (int d = 0; d < 3; d++)
        chk($sformatf("vec%0d_res_g%0d", i, d), 32'(res(d)),
            32'({tv[i].sum, tv[i].co, tv[i].ov, tv[i].g, tv[i].p}));
    end
    @(negedge clk);

    // Back-pressure: five beats, consumer stalled for the first four cycles
    idx = 1; got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = (c >= 4);
      in_valid  = (idx <= 5);
      a = 16'(idx); b = 16'(idx); c_in = 1'b0; sub = 1'b0;
      #1;
      if (c == 0) chk("bp_rdy_first", 32'(in_ready_w), 32'h7);
      if (c == 2 || c == 3) begin
        chk($sformatf("bp_rdy_held_c%0d", c), 32'(in_ready_w), 32'd0);
        chk($sformatf("bp_vld_held_c%0d", c), 32'(out_valid_w), 32'h7);
      end
      if (out_valid_w[0] && !out_ready)
        for (int d = 0; d < 3; d++) chk($sformatf("bp_stable_g%0d", d), 32'(sum_w[d]), 32'd2);
      acc = in_valid && in_ready_w[0];
      if (out_valid_w[0] && out_ready) begin
        got++;
        for (int d = 0; d < 3; d++)
          chk($sformatf("bp_order%0d_g%0d", got, d), 32'(sum_w[d]), 32'(2 * got));
      end
      @(posedge clk);
      if (acc) idx++;
    end
    chk("bp_count", 32'(got), 32'd5);
    @(negedge clk);
    in_valid = 1'b0;

    // Reset while two beats sit stalled in the pipe
    out_ready = 1'b0;
    a = 16'h0100; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h0200; b = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("mr_pre_valid", 32'(out_valid_w), 32'h7);
    rst = 1'b1;
    #1;
    chk("mr_out_valid", 32'(out_valid_w), 32'd0);
    for (int d = 0; d < 3; d++) chk($sformatf("mr_res_g%0d", d), 32'(res(d)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("mr_in_ready", 32'(in_ready_w), 32'h7);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 chk($sformatf("mr_no_stale_c%0d", c), 32'(out_valid_w), 32'd0);
    end

    // Random streaming with random stalls on both sides
    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    while ((sent < NBEATS || q.size() > 0) && cyc < CYC_LIMIT) begin
      @(negedge clk);
      if (!in_valid || acc) begin
        in_valid = 1'b0;
        if (sent < NBEATS && $urandom_range(3) != 0) begin
          in_valid = 1'b1;
          a = 16'($urandom); b = 16'($urandom);
          c_in = 1'($urandom); sub = 1'($urandom);
        end
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      acc = in_valid && in_ready_w[0];
      if (acc) begin
        q.push_back(model(a, b, c_in, sub));
        sent++;
      end
      if (out_valid_w[0] && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra_beat", 32'd1, 32'd0);
        end else begin
          exp_r = q.pop_front();
          for (int d = 0; d < 3; d++)
            chk($sformatf("rnd%0d_g%0d", got, d), 32'(res(d)), 32'(exp_r));
        end
        got++;
      end
      @(posedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_timeout", 32'(cyc >= CYC_LIMIT), 32'd0);
    chk("rnd_count", 32'(got), 32'(NBEATS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
